// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants, sync polarity encodings and counter width helper.
// Purely compile-time content; no logic, no latency, no flow control.
// Modes are expressed per axis so one counter template serves both directions.
package vga_timing_pkg;

    localparam bit SYNC_NEG = 1'b0;
    localparam bit SYNC_POS = 1'b1;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_mode_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam axis_mode_t MODE_640X480_H    = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam axis_mode_t MODE_640X480_V    = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam bit         MODE_640X480_HPOL = SYNC_NEG;
    localparam bit         MODE_640X480_VPOL = SYNC_NEG;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam axis_mode_t MODE_800X600_H    = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam axis_mode_t MODE_800X600_V    = '{active: 600, fp: 1,  sync: 4,   bp: 23};
    localparam bit         MODE_800X600_HPOL = SYNC_POS;
    localparam bit         MODE_800X600_VPOL = SYNC_POS;

    // Smallest width able to hold positions 0 .. total-1.
    function automatic int cnt_width(input int total);
        int w;
        w = 1;
        while ((w < 31) && ((32'sd1 << w) < total)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync decode and next-position active decode.
// Latency: count/sync update on the clk_25 edge where adv=1; last and active_nxt are combinational.
// Backpressure: none; adv=0 freezes every register in the axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = SYNC_NEG,
    parameter int CNT_W  = 10
) (
    input  logic             clk_25,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             last,
    output logic             sync,
    output logic             active_nxt
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

    if ((ACTIVE <= 0) || (FP <= 0) || (SYNC <= 0) || (BP <= 0)) begin : g_bad_timing
        $error("vga_axis_counter: every timing parameter must be non-zero");
    end
    if ((CNT_W <= 0) || (CNT_W < cnt_width(TOTAL))) begin : g_bad_width
        $error("vga_axis_counter: CNT_W too narrow for the axis total");
    end

    logic [CNT_W-1:0] count_nxt;
    logic             sync_nxt;

    assign last = (count == LAST_POS);

    always_comb begin
        count_nxt = count;
        if (adv) begin
            count_nxt = last ? '0 : count + 1'b1;
        end
    end

    // Decoding the next position keeps flags aligned with the count they describe.
    assign active_nxt = (count_nxt < ACT_END);
    assign sync_nxt   = ((count_nxt >= SYNC_BEG) && (count_nxt < SYNC_END)) ? POL : ~POL;

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            count <= LAST_POS;
            sync  <= ~POL;
        end else if (adv) begin
            count <= count_nxt;
            sync  <= sync_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: coordinates, syncs, active video, line/frame strobes.
// Latency: all outputs registered, updated one clk_25 edge after pix_en, with zero mutual skew.
// Backpressure: none; pix_en=0 holds all state. Frame counter behind VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_640X480_H.active,
    parameter int H_FP     = MODE_640X480_H.fp,
    parameter int H_SYNC   = MODE_640X480_H.sync,
    parameter int H_BP     = MODE_640X480_H.bp,
    parameter int V_ACTIVE = MODE_640X480_V.active,
    parameter int V_FP     = MODE_640X480_V.fp,
    parameter int V_SYNC   = MODE_640X480_V.sync,
    parameter int V_BP     = MODE_640X480_V.bp,
    parameter bit H_POL    = MODE_640X480_HPOL,
    parameter bit V_POL    = MODE_640X480_VPOL,
    parameter int CNT_W    = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    parameter int FRAME_W  = 8
`endif
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic               pix_en,
    output logic [CNT_W-1:0]   x_count,
    output logic [CNT_W-1:0]   y_count,
    output logic               hsync,
    output logic               vsync,
    output logic               active_pixel,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_count
`endif
);

    logic h_last;
    logic v_last;
    logic h_act_nxt;
    logic v_act_nxt;
    logic v_adv;

    // The vertical axis only moves on the pixel that wraps the line.
    assign v_adv = pix_en & h_last;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk_25     (clk_25),
        .rst        (rst),
        .adv        (pix_en),
        .count      (x_count),
        .last       (h_last),
        .sync       (hsync),
        .active_nxt (h_act_nxt)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk_25     (clk_25),
        .rst        (rst),
        .adv        (v_adv),
        .count      (y_count),
        .last       (v_last),
        .sync       (vsync),
        .active_nxt (v_act_nxt)
    );

    // Strobes are registered from the wrap condition, so they mark the position being entered.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            active_pixel <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (pix_en) begin
            active_pixel <= h_act_nxt & v_act_nxt;
            line_start   <= h_last;
            frame_start  <= h_last & v_last;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    if (FRAME_W <= 0) begin : g_bad_frame_w
        $error("vga_timing_gen: FRAME_W must be non-zero");
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (pix_en && h_last && v_last) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule
